// File: rtl/ps2_key_tx_if.sv
// Key-event handshake between an event producer and the PS/2 device-side transmitter.
interface ps2_key_tx_if;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, key_ext, key_break, key_valid, input key_ready);
    modport slave  (input key_code, key_ext, key_break, key_valid, output key_ready);
endinterface

// File: rtl/ps2_key_tx.sv
// PS/2 keyboard-side transmitter: expands one key event into E0/F0/code bytes and
// sends each as an 11-bit device-clocked frame, backing off when the host inhibits the clock.
module ps2_key_tx #(
    parameter int HALF_PERIOD = 4000,
    parameter int GAP         = 8000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_key_tx_if.slave  key,
    input  logic         ps2_clk_i,
    output logic         ps2_clk_o,
    output logic         ps2_data_o,
    output logic         busy,
    output logic         byte_done
);
    localparam logic [15:0] PhaseReload = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GapReload   = 16'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;

    state_e      state_q;
    logic [1:0]  sync_q;
    logic [7:0]  code_q;
    logic        break_q;
    logic [1:0]  idx_q;
    logic [10:0] shift_q;
    logic [15:0] phase_q;
    logic [3:0]  bit_q;
    logic [15:0] gap_q;
    logic        clk_q;
    logic        data_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  byte_d;
    logic [10:0] frame_d;
    logic        inhibit_d;

    // idx 0 = E0 prefix, 1 = F0 break prefix, 2 = the key code itself (always last)
    always_comb begin
        case (idx_q)
            2'd0:    byte_d = 8'hE0;
            2'd1:    byte_d = 8'hF0;
            default: byte_d = code_q;
        endcase
    end

    assign frame_d   = {1'b1, ~^byte_d, byte_d, 1'b0};
    assign inhibit_d = !sync_q[1] && clk_q && (bit_q <= 4'd9);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync_q  <= 2'b11;
            code_q  <= 8'h00;
            break_q <= 1'b0;
            idx_q   <= 2'd0;
            shift_q <= 11'h7FF;
            phase_q <= 16'd0;
            bit_q   <= 4'd0;
            gap_q   <= 16'd0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ps2_clk_i};
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (key.key_valid && ready_q) begin
                        code_q  <= key.key_code;
                        break_q <= key.key_break;
                        idx_q   <= key.key_ext ? 2'd0 : (key.key_break ? 2'd1 : 2'd2);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shift_q <= frame_d;
                    if (sync_q[1]) begin
                        data_q  <= frame_d[0];
                        clk_q   <= 1'b1;
                        phase_q <= PhaseReload;
                        bit_q   <= 4'd0;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Abort leaves idx_q untouched so the same byte is resent after the gap
                    if (inhibit_d) begin
                        clk_q   <= 1'b1;
                        data_q  <= 1'b1;
                        gap_q   <= GapReload;
                        state_q <= S_GAP;
                    end else if (phase_q != 16'd0) begin
                        phase_q <= phase_q - 16'd1;
                    end else begin
                        phase_q <= PhaseReload;
                        if (clk_q) begin
                            clk_q <= 1'b0;
                        end else begin
                            clk_q <= 1'b1;
                            if (bit_q == 4'd10) begin
                                done_q <= 1'b1;
                                data_q <= 1'b1;
                                if (idx_q == 2'd2) begin
                                    state_q <= S_IDLE;
                                end else begin
                                    idx_q   <= (idx_q == 2'd0 && !break_q) ? 2'd2 : idx_q + 2'd1;
                                    gap_q   <= GapReload;
                                    state_q <= S_GAP;
                                end
                            end else begin
                                bit_q   <= bit_q + 4'd1;
                                shift_q <= {1'b1, shift_q[10:1]};
                                data_q  <= shift_q[1];
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == 16'd0) begin
                        state_q <= S_LOAD;
                    end else begin
                        gap_q <= gap_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign key.key_ready = ready_q;
    assign ps2_clk_o     = clk_q;
    assign ps2_data_o    = data_q;
    assign busy          = busy_q;
    assign byte_done     = done_q;
endmodule

// File: tb/tb_ps2_key_tx.sv
// Scoreboard bench for ps2_key_tx: a line monitor decodes frames on ps2_clk_o falls
// and each scenario task pops expected bytes and compares them inline.
module tb_ps2_key_tx;
    localparam int H      = 4;
    localparam int G      = 8;
    localparam int BUDGET = 400;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic ps2_clk_i = 1'b1;
    logic ps2_clk_o;
    logic ps2_data_o;
    logic busy;
    logic byte_done;

    ps2_key_tx_if key_if ();

    ps2_key_tx #(.HALF_PERIOD(H), .GAP(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key_if),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o),
        .busy       (busy),
        .byte_done  (byte_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int rd_ptr = 0;
    logic [7:0] exp_q [$];

    logic [10:0] mon_bits = 11'h0;
    int          mon_n = 0;
    int          mon_first = 0;
    logic        mon_prev_clk = 1'b1;
    logic        mon_prev_data = 1'b1;
    int          flush_req = 0;
    int          flush_seen = 0;
    int          bad_changes = 0;
    logic [10:0] rx_frame [0:63];
    int          rx_n [0:63];
    int          rx_done_cyc [0:63];
    int          rx_first_cyc [0:63];
    int          rx_cnt = 0;

    // Host-side receiver: sample data on each falling clock, close the frame on byte_done
    always @(negedge clk) begin
        mon_prev_clk  <= ps2_clk_o;
        mon_prev_data <= ps2_data_o;
        if (!rst && !mon_prev_clk && !ps2_clk_o && ps2_data_o !== mon_prev_data)
            bad_changes <= bad_changes + 1;
        if (rst || flush_req != flush_seen) begin
            mon_n      <= 0;
            flush_seen <= flush_req;
        end else if (mon_prev_clk && !ps2_clk_o) begin
            if (mon_n < 11) mon_bits[mon_n[3:0]] <= ps2_data_o;
            if (mon_n == 0) mon_first <= cyc;
            mon_n <= mon_n + 1;
        end else if (byte_done) begin
            rx_frame[rx_cnt[5:0]]     <= mon_bits;
            rx_n[rx_cnt[5:0]]         <= mon_n;
            rx_done_cyc[rx_cnt[5:0]]  <= cyc;
            rx_first_cyc[rx_cnt[5:0]] <= mon_first;
            rx_cnt <= rx_cnt + 1;
            mon_n  <= 0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_event(input logic [7:0] code, input logic ext, input logic brk,
                              output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (key_if.key_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        key_if.key_code  = code;
        key_if.key_ext   = ext;
        key_if.key_break = brk;
        key_if.key_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        key_if.key_valid = 1'b0;
        if (ext) exp_q.push_back(8'hE0);
        if (brk) exp_q.push_back(8'hF0);
        exp_q.push_back(code);
    endtask

    task automatic wait_frame(output bit ok);
        int n;
        n = 0;
        while (rx_cnt <= rd_ptr && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        ok = (rx_cnt > rd_ptr);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (key_if.key_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ps2_clk_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_clk: got %b, expected 1", ps2_clk_o); end
        checks++; if (ps2_data_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_data: got %b, expected 1", ps2_data_o); end
        checks++; if (key_if.key_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", key_if.key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (byte_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", byte_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        int acc, n, done_cyc;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rd_ptr = rx_cnt;
        send_event(8'h29, 1'b0, 1'b0, acc);
        checks++; if (key_if.key_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_fall: got %b, expected 0", key_if.key_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_rise: got %b, expected 1", busy); end
        n = 0;
        while (byte_done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        checks++; if (byte_done !== 1'b1) begin errors++; $display("[TB] FAIL single_done_seen: got %b, expected 1", byte_done); end
        checks++; if (done_cyc != acc + 1 + 22 * H) begin errors++; $display("[TB] FAIL single_done_cycle: got %0d, expected %0d", done_cyc, acc + 1 + 22 * H); end
        checks++; if (key_if.key_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_at_done: got %b, expected 0", key_if.key_ready); end
        @(negedge clk);
        checks++; if (key_if.key_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_return: got %b, expected 1", key_if.key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_fall: got %b, expected 0", busy); end
        wait_frame(ok);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL single_frame: got no frame, expected %b", 11'b10001010010);
        end else begin
            if (rx_frame[rd_ptr[5:0]] !== 11'b10001010010) begin errors++; $display("[TB] FAIL single_frame: got %b, expected %b", rx_frame[rd_ptr[5:0]], 11'b10001010010); end
            checks++; if (rx_n[rd_ptr[5:0]] != 11) begin errors++; $display("[TB] FAIL single_falls: got %0d, expected 11", rx_n[rd_ptr[5:0]]); end
            checks++; if (rx_first_cyc[rd_ptr[5:0]] != acc + 1 + H) begin errors++; $display("[TB] FAIL single_first_fall: got %0d, expected %0d", rx_first_cyc[rd_ptr[5:0]], acc + 1 + H); end
            rd_ptr++;
        end
    endtask

    task automatic test_ext_press();
        int acc;
        int done_c [2];
        int first_c [2];
        bit ok;
        logic [7:0] eb;
        send_event(8'h6B, 1'b1, 1'b0, acc);
        for (int i = 0; i < 2; i++) begin
            wait_frame(ok);
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if (!ok) begin
                errors++; $display("[TB] FAIL ext_press_frame%0d: got no frame, expected byte %h", i, eb);
                done_c[i] = 0; first_c[i] = 0;
            end else begin
                if (rx_frame[rd_ptr[5:0]] !== frame_of(eb)) begin errors++; $display("[TB] FAIL ext_press_frame%0d: got %b, expected %b", i, rx_frame[rd_ptr[5:0]], frame_of(eb)); end
                done_c[i]  = rx_done_cyc[rd_ptr[5:0]];
                first_c[i] = rx_first_cyc[rd_ptr[5:0]];
                rd_ptr++;
            end
        end
        checks++; if (first_c[1] != done_c[0] + G + 1 + H) begin errors++; $display("[TB] FAIL ext_press_gap: got %0d, expected %0d", first_c[1], done_c[0] + G + 1 + H); end
        wait_ready();
    endtask

    task automatic test_ext_release();
        int acc;
        bit ok;
        logic [7:0] eb;
        logic [2:0] par_exp;
        par_exp = 3'b010;
        send_event(8'h75, 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            wait_frame(ok);
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if (!ok) begin
                errors++; $display("[TB] FAIL ext_release_frame%0d: got no frame, expected byte %h", i, eb);
            end else begin
                if (rx_frame[rd_ptr[5:0]] !== frame_of(eb)) begin errors++; $display("[TB] FAIL ext_release_frame%0d: got %b, expected %b", i, rx_frame[rd_ptr[5:0]], frame_of(eb)); end
                checks++; if (rx_frame[rd_ptr[5:0]][9] !== par_exp[2 - i]) begin errors++; $display("[TB] FAIL ext_release_parity%0d: got %b, expected %b", i, rx_frame[rd_ptr[5:0]][9], par_exp[2 - i]); end
                rd_ptr++;
            end
        end
        wait_ready();
    endtask

    task automatic test_offer_busy();
        int acc;
        bit ok;
        logic ready_seen;
        logic [7:0] eb;
        send_event(8'h29, 1'b0, 1'b0, acc);
        ready_seen = 1'b0;
        key_if.key_code  = 8'h74;
        key_if.key_ext   = 1'b0;
        key_if.key_break = 1'b0;
        key_if.key_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            ready_seen = ready_seen | key_if.key_ready;
        end
        key_if.key_valid = 1'b0;
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("[TB] FAIL busy_ready_low: got %b, expected 0", ready_seen); end
        wait_frame(ok);
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL busy_first_frame: got no frame, expected byte %h", eb);
        end else begin
            if (rx_frame[rd_ptr[5:0]] !== frame_of(eb)) begin errors++; $display("[TB] FAIL busy_first_frame: got %b, expected %b", rx_frame[rd_ptr[5:0]], frame_of(eb)); end
            rd_ptr++;
        end
        wait_ready();
        repeat (2 * G + 30) @(negedge clk);
        checks++; if (rx_cnt != rd_ptr) begin errors++; $display("[TB] FAIL busy_no_extra: got %0d frames, expected %0d", rx_cnt, rd_ptr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_not_queued: got %b, expected 0", busy); end
        send_event(8'h74, 1'b1, 1'b0, acc);
        for (int i = 0; i < 2; i++) begin
            wait_frame(ok);
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            checks++;
            if (!ok) begin
                errors++; $display("[TB] FAIL busy_reoffer_frame%0d: got no frame, expected byte %h", i, eb);
            end else begin
                if (rx_frame[rd_ptr[5:0]] !== frame_of(eb)) begin errors++; $display("[TB] FAIL busy_reoffer_frame%0d: got %b, expected %b", i, rx_frame[rd_ptr[5:0]], frame_of(eb)); end
                rd_ptr++;
            end
        end
        wait_ready();
    endtask

    task automatic test_inhibit();
        int acc, n, falls, lows, r0;
        logic prev;
        bit ok;
        logic [7:0] eb;
        r0 = rx_cnt;
        send_event(8'h72, 1'b0, 1'b0, acc);
        prev = ps2_clk_o;
        falls = 0;
        n = 0;
        while (falls < 4 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (prev && !ps2_clk_o) falls++;
            prev = ps2_clk_o;
        end
        while (ps2_clk_o !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++; if (falls != 4) begin errors++; $display("[TB] FAIL inhibit_reach_cell4: got %0d falls, expected 4", falls); end
        ps2_clk_i = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (ps2_clk_o !== 1'b1) begin errors++; $display("[TB] FAIL inhibit_clk_high: got %b, expected 1", ps2_clk_o); end
        checks++; if (ps2_data_o !== 1'b1) begin errors++; $display("[TB] FAIL inhibit_data_high: got %b, expected 1", ps2_data_o); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL inhibit_busy: got %b, expected 1", busy); end
        checks++; if (rx_cnt != r0) begin errors++; $display("[TB] FAIL inhibit_no_done: got %0d, expected %0d", rx_cnt, r0); end
        flush_req++;
        falls = 0;
        lows = 0;
        prev = ps2_clk_o;
        repeat (24) begin
            @(negedge clk);
            if (prev && !ps2_clk_o) falls++;
            if (ps2_data_o !== 1'b1) lows++;
            prev = ps2_clk_o;
        end
        checks++; if (falls != 0) begin errors++; $display("[TB] FAIL inhibit_hold_falls: got %0d, expected 0", falls); end
        checks++; if (lows != 0) begin errors++; $display("[TB] FAIL inhibit_hold_data: got %0d low cycles, expected 0", lows); end
        ps2_clk_i = 1'b1;
        wait_frame(ok);
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL inhibit_retransmit: got no frame, expected byte %h", eb);
        end else begin
            if (rx_frame[rd_ptr[5:0]] !== frame_of(eb)) begin errors++; $display("[TB] FAIL inhibit_retransmit: got %b, expected %b", rx_frame[rd_ptr[5:0]], frame_of(eb)); end
            rd_ptr++;
        end
        wait_ready();
        repeat (4) @(negedge clk);
        checks++; if (rx_cnt != r0 + 1) begin errors++; $display("[TB] FAIL inhibit_one_done: got %0d, expected %0d", rx_cnt - r0, 1); end
    endtask

    task automatic test_reset_mid();
        int acc, n, falls;
        logic prev;
        bit ok;
        logic [7:0] eb;
        send_event(8'h72, 1'b0, 1'b0, acc);
        prev = ps2_clk_o;
        falls = 0;
        n = 0;
        while (falls < 7 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (prev && !ps2_clk_o) falls++;
            prev = ps2_clk_o;
        end
        checks++; if (ps2_clk_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_in_cell6: got clk %b, expected 0", ps2_clk_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ps2_clk_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_clk: got %b, expected 1", ps2_clk_o); end
        checks++; if (ps2_data_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_data: got %b, expected 1", ps2_data_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b, expected 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rd_ptr = rx_cnt;
        repeat (3) @(negedge clk);
        checks++; if (key_if.key_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b, expected 1", key_if.key_ready); end
        checks++; if (ps2_clk_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_no_resume: got %b, expected 1", ps2_clk_o); end
        send_event(8'h29, 1'b0, 1'b0, acc);
        wait_frame(ok);
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checks++;
        if (!ok) begin
            errors++; $display("[TB] FAIL rstmid_next_frame: got no frame, expected byte %h", eb);
        end else begin
            if (rx_frame[rd_ptr[5:0]] !== frame_of(eb)) begin errors++; $display("[TB] FAIL rstmid_next_frame: got %b, expected %b", rx_frame[rd_ptr[5:0]], frame_of(eb)); end
            rd_ptr++;
        end
        wait_ready();
    endtask

    initial begin
        key_if.key_code  = 8'h00;
        key_if.key_ext   = 1'b0;
        key_if.key_break = 1'b0;
        key_if.key_valid = 1'b0;
        $display("[TB] starting ps2_key_tx bench");
        test_reset();
        test_single_byte();
        test_ext_press();
        test_ext_release();
        test_offer_busy();
        test_inhibit();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++; if (bad_changes != 0) begin errors++; $display("[TB] FAIL data_stable_low_clk: got %0d changes, expected 0", bad_changes); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_drained: got %0d left, expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_tx.md
# ps2_key_tx

PS/2 device-side transmitter: the keyboard end of the link that `tetris_top` receives on `ps2_clk`/`ps2_data`. It accepts one key event per handshake as a Set-2 code plus flags. It expands the event into a 1–3 byte scancode sequence (`E0` prefix, `F0` break prefix, code). It serialises each byte as an 11-bit PS/2 frame, with the device generating the clock. It serves as the keyboard model in system benches and as the on-board key injector for the demo build, and it honours host clock-inhibit.

## Interface
Parameters:
- `HALF_PERIOD`, 4000: sys-clock cycles per PS/2 clock phase (12.5 kHz at 100 MHz); legal range 4–65535.
- `GAP`, 8000: idle sys-clock cycles, lines high, between consecutive bytes and after an aborted frame.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_code`  in  8  Set-2 code byte (e.g. `6B` left, `74` right, `72` down, `75` up, `29` space).
- `key_ext`  in  1  extended key; prefix the sequence with `E0`.
- `key_break`  in  1  release event; insert `F0` before the code.
- `key_valid`  in  1  event offered.
- `key_ready`  out  1  block can accept an event.
- `ps2_clk_i`  in  1  sensed line clock, used for host inhibit (asynchronous).
- `ps2_clk_o`  out  1  driven clock, idle 1.
- `ps2_data_o`  out  1  driven data, idle 1.
- `busy`  out  1  sequence in progress.
- `byte_done`  out  1  one-cycle pulse when a frame completes its stop bit.

## Operation
- **Acceptance.** An event is accepted on the rising edge where `key_valid && key_ready`. `key_code`, `key_ext` and `key_break` are latched on that edge. `key_valid` while `key_ready` is 0 is ignored and is not queued.
- **Byte sequence.** Order is `E0` if ext, then `F0` if break, then `key_code`; byte count is 1–3. A 2-bit index walks the sequence.
- **Frame format.** Start bit 0; 8 data bits LSB first; odd parity (data plus parity has an odd number of ones); stop bit 1.
- **FSM states:**
  - IDLE: `key_ready` = 1. Accept event → LOAD.
  - LOAD: select the next byte and build the 11-bit shift register. If synchronised `ps2_clk_i` = 1 → SEND; otherwise stay (host inhibit).
  - SEND: 11 bit cells. Bit k is presented during cell k, which is one high phase followed by one low phase of `ps2_clk_o`. After cell 10 completes → pulse `byte_done`. If more bytes remain → GAP, else → IDLE.
  - GAP: lines high for `GAP` cycles → LOAD.
- **Inhibit.** `ps2_clk_i` passes through a 2-flop synchroniser.
  - In SEND, a 0 sampled while `ps2_clk_o` = 1, before the falling edge of cell 9 (parity), aborts the frame. Both outputs go to 1, the FSM goes to GAP, and the same byte is retransmitted.
  - From the cell-9 falling edge onward, inhibit is ignored and the frame completes.
  - In LOAD, a 0 holds the FSM.
- **Counters.** The phase counter is 16 bits and reloads at `HALF_PERIOD`-1. The bit counter is 4 bits, 0–10. The gap counter is 16 bits.

## Timing
- **Reset values.** `ps2_clk_o` = 1, `ps2_data_o` = 1, `key_ready` = 1, `busy` = 0, `byte_done` = 0, FSM in IDLE.
- **Reset mid-frame.** Asserting `rst` forces all outputs to their reset values asynchronously. The partial frame is discarded and not resumed.
- **Handshake timing.**
  - `key_ready` falls the cycle after acceptance.
  - `busy` rises the cycle after acceptance.
  - `key_ready` returns to 1 the cycle after the last `byte_done`.
  - `busy` falls in the same cycle that `key_ready` returns to 1.
- **Frame start.** LOAD occupies one cycle. With no inhibit, the first frame begins 2 cycles after acceptance.
- **Cell timing.** Let t0 be the SEND entry cycle and H = `HALF_PERIOD`.
  - Bit k is on `ps2_data_o` from t0+2kH.
  - `ps2_clk_o` falls at t0+(2k+1)H and rises at t0+(2k+2)H.
  - Data changes only while `ps2_clk_o` = 1.
- **Frame length.** Exactly 22H cycles, with `byte_done` asserted in cycle t0+22H. The gap between frames is `GAP` + 1 cycles.

## Test plan
1. **Single byte.** rst pulse, then `29`, ext=0, break=0.
   - One frame on `ps2_data_o`: 0, 1,0,0,1,0,1,0,0, 0, 1.
   - 11 falling edges of `ps2_clk_o`, one `byte_done` at t0+22H.
   - `key_ready` returns 1 cycle later.
2. **Extended press.** `6B`, ext=1 → frames `E0` (parity 0) then `6B` (parity 0), separated by `GAP`+1 idle cycles. Two `byte_done` pulses.
3. **Extended release.** `75`, ext=1, break=1 → `E0`, `F0` (parity 1), `75` (parity 0), decoded by the `tetris_top` receiver as a release of the up key.
4. **Offer while busy.** Offer `74` while busy → not accepted and no extra frame. A re-offer after `key_ready` = 1 yields the `E0 74` sequence.
5. **Host inhibit mid-frame.** Pull `ps2_clk_i` low for 100 µs during cell 4 of `72` → outputs go high and wait `GAP`. Then a full retransmission of `72`, with exactly one `byte_done` for that byte.
6. **Reset mid-frame.** Assert `rst` mid-frame during cell 6 → `ps2_clk_o` = `ps2_data_o` = 1 immediately, and `key_ready` = 1 after release. The next event transmits cleanly.
